// File: rtl/bit_run_counter_pipe.sv
// Pipelined run counter: per word, counts maximal runs of the target bit
// of length >= MIN_RUN and reports the longest target-bit run.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      input handshake for in_data and in_polarity
//   in_data                word to scan, bit 0 first
//   in_polarity            1: runs of ones, 0: runs of zeros
//   out_valid/out_ready    output handshake
//   out_cnt                qualifying run count (saturating)
//   out_max_run            longest target-bit run (saturating)
module bit_run_counter_pipe #(
    parameter int DATA_W  = 32,
    parameter int SEG_W   = 8,
    parameter int MIN_RUN = 1,
    parameter int CNT_W   = 6,
    parameter int RUN_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_polarity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [RUN_W-1:0]  out_max_run
);

    localparam int STAGES = DATA_W / SEG_W;
    localparam logic [RUN_W-1:0] MIN_R = RUN_W'(MIN_RUN);

    typedef struct packed {
        logic [RUN_W-1:0] run;
        logic [CNT_W-1:0] cnt;
        logic [RUN_W-1:0] mx;
    } acc_t;

    function automatic logic [CNT_W-1:0] sat_cnt(
        input logic [CNT_W-1:0] c
    );
        sat_cnt = (&c) ? c : c + CNT_W'(1);
    endfunction

    function automatic acc_t scan_seg(
        input logic [SEG_W-1:0] seg,
        input logic             pol,
        input acc_t             a
    );
        acc_t r;
        r = a;
        for (int i = 0; i < SEG_W; i++) begin
            if (seg[i] == pol) begin
                if (!(&r.run)) r.run = r.run + RUN_W'(1);
                if (r.run > r.mx) r.mx = r.run;
            end else begin
                if (r.run >= MIN_R) r.cnt = sat_cnt(r.cnt);
                r.run = '0;
            end
        end
        return r;
    endfunction

    // Stage k holds the word with segment k in its low SEG_W bits,
    // plus the run state accumulated over segments 0..k-1.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] pol_q;
    logic [DATA_W-1:0] dat_q [STAGES];
    acc_t              acc_q [STAGES];
    acc_t              nxt_d [STAGES];
    acc_t              fin_d;
    logic [STAGES-1:0] adv;
    logic              out_adv;

    logic              out_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RUN_W-1:0]  max_q;

    // A stage may load when it and every later register cannot be blocked
    // by a stalled sink; computed as a running AND from the output back.
    always_comb begin
        logic stall;
        out_adv = ~(out_valid_q & ~out_ready);
        stall   = out_valid_q & ~out_ready;
        adv     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stall  = stall & vld_q[k];
            adv[k] = ~stall;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_d[k] = scan_seg(dat_q[k][SEG_W-1:0], pol_q[k], acc_q[k]);
        end
        // A run still open at the last bit closes here.
        fin_d = nxt_d[STAGES-1];
        if (fin_d.run >= MIN_R) fin_d.cnt = sat_cnt(fin_d.cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            pol_q       <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
                acc_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            max_q       <= '0;
        end else begin
            if (adv[0]) vld_q[0] <= in_valid;
            if (adv[0] && in_valid) begin
                dat_q[0] <= in_data;
                pol_q[0] <= in_polarity;
                acc_q[0] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) vld_q[k] <= vld_q[k-1];
                if (adv[k] && vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1] >> SEG_W;
                    pol_q[k] <= pol_q[k-1];
                    acc_q[k] <= nxt_d[k-1];
                end
            end
            if (out_adv) out_valid_q <= vld_q[STAGES-1];
            if (out_adv && vld_q[STAGES-1]) begin
                cnt_q <= fin_d.cnt;
                max_q <= fin_d.mx;
            end
        end
    end

    assign in_ready    = adv[0];
    assign out_valid   = out_valid_q;
    assign out_cnt     = cnt_q;
    assign out_max_run = max_q;

endmodule

// File: tb/tb_bit_run_counter_pipe.sv
// Directed bench for bit_run_counter_pipe: fixed words with known
// counts, a stalled burst, and reset with words in flight.
module tb_bit_run_counter_pipe;

    localparam int DW = 32;
    localparam int SW = 8;
    localparam int S  = DW / SW;
    localparam int CW = 6;
    localparam int RW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_polarity;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cnt;
    logic [RW-1:0] out_max_run;

    logic          in_ready2;
    logic          out_valid2;
    logic [CW-1:0] out_cnt2;
    logic [RW-1:0] out_max_run2;

    int checks = 0;
    int errors = 0;

    bit_run_counter_pipe #(
        .DATA_W(DW), .SEG_W(SW), .MIN_RUN(1), .CNT_W(CW), .RUN_W(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_polarity(in_polarity),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cnt(out_cnt), .out_max_run(out_max_run)
    );

    bit_run_counter_pipe #(
        .DATA_W(DW), .SEG_W(SW), .MIN_RUN(2), .CNT_W(CW), .RUN_W(RW)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_polarity(in_polarity),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_cnt(out_cnt2), .out_max_run(out_max_run2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [DW-1:0] d, input logic p,
                                  input int minr, output int c,
                                  output int m);
        int run;
        run = 0;
        c = 0;
        m = 0;
        for (int i = 0; i < DW; i++) begin
            if (d[i] == p) begin
                run++;
                if (run > m) m = run;
            end else begin
                if (run >= minr) c++;
                run = 0;
            end
        end
        if (run >= minr) c++;
    endfunction

    task automatic run1(input string tag, input logic [DW-1:0] d,
                        input logic p, input int ec, input int em,
                        input int ec2, input int em2);
        int lat;
        @(posedge clk); #1;
        in_valid    = 1'b1;
        in_data     = d;
        in_polarity = p;
        out_ready   = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, S);
        check({tag, "_cnt"}, int'(out_cnt), ec);
        check({tag, "_max"}, int'(out_max_run), em);
        check({tag, "_cnt2"}, int'(out_cnt2), ec2);
        check({tag, "_max2"}, int'(out_max_run2), em2);
        @(posedge clk); #1;
        check({tag, "_drain"}, int'(out_valid), 0);
    endtask

    logic [DW-1:0] w  [8];
    logic          pl [8];

    initial begin
        int sent, emitted, cyc, dropped, stalled_prev, pc, pm;
        int ec, em, seen;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_polarity = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_cnt", int'(out_cnt), 0);
        check("rst_max", int'(out_max_run), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(in_ready), 1);

        run1("ones_p1", 32'hFFFF_FFFF, 1'b1, 1, 32, 1, 32);
        run1("ones_p0", 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0);
        run1("alt_p1", 32'h5555_5555, 1'b1, 16, 1, 0, 1);
        run1("bnd_p1", 32'h0000_0180, 1'b1, 1, 2, 1, 2);
        run1("bnd_p0", 32'h0000_0180, 1'b0, 2, 23, 2, 23);
        run1("end_p1", 32'h8000_0001, 1'b1, 2, 1, 0, 1);
        run1("end_p0", 32'h8000_0001, 1'b0, 1, 30, 1, 30);

        // Burst of 8 with the sink stalled for 5 cycles.
        for (int i = 0; i < 8; i++) begin
            w[i]  = $urandom;
            pl[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        emitted = 0;
        dropped = 0;
        stalled_prev = 0;
        pc = 0;
        pm = 0;
        for (cyc = 0; emitted < 8 && cyc < 200; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc < 8);
            if (sent < 8) begin
                in_valid    = 1'b1;
                in_data     = w[sent];
                in_polarity = pl[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (stalled_prev != 0) begin
                check("t5_hold_v", int'(out_valid), 1);
                check("t5_hold_c", int'(out_cnt), pc);
                check("t5_hold_m", int'(out_max_run), pm);
            end
            if (!in_ready && dropped == 0) begin
                dropped = 1;
                check("t5_full", sent - emitted, S + 1);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                model(w[emitted], pl[emitted], 1, ec, em);
                check("t5_cnt", int'(out_cnt), ec);
                check("t5_max", int'(out_max_run), em);
                model(w[emitted], pl[emitted], 2, ec, em);
                check("t5_cnt2", int'(out_cnt2), ec);
                check("t5_max2", int'(out_max_run2), em);
                emitted++;
            end
            stalled_prev = int'(out_valid && !out_ready);
            pc = int'(out_cnt);
            pm = int'(out_max_run);
        end
        in_valid = 1'b0;
        check("t5_count", emitted, 8);
        check("t5_dropped", dropped, 1);
        check("t5_sent", sent, 8);

        // Reset with three words in flight, the oldest held at the output.
        @(posedge clk); #1;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_polarity = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hFFFF_FFFF >> i;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("t6_pre_v", int'(out_valid), 1);
        check("t6_pre_m", int'(out_max_run), 32);
        rst_n = 1'b0;
        #1;
        check("t6_rst_v", int'(out_valid), 0);
        check("t6_rst_c", int'(out_cnt), 0);
        check("t6_rst_m", int'(out_max_run), 0);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || out_valid2) seen++;
        end
        check("t6_stale", seen, 0);
        run1("t6_new", 32'h0000_0F0F, 1'b1, 2, 4, 2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
